// File: rtl/bingo_board_writer_if.sv
// Mark-request channel between the game controller (master) and the board writer (slave).
interface bingo_board_writer_if;
  logic       mark_valid;
  logic [4:0] mark_num;
  logic       mark_ready;
  logic       mark_hit;
  logic       mark_miss;

  modport master (
    output mark_valid,
    output mark_num,
    input  mark_ready,
    input  mark_hit,
    input  mark_miss
  );

  modport slave (
    input  mark_valid,
    input  mark_num,
    output mark_ready,
    output mark_hit,
    output mark_miss
  );
endinterface

// File: rtl/bingo_board_writer.sv
// Builds a shuffled 5x5 bingo board, clears called numbers and tracks completed lines.
module bingo_board_writer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned WIN_LINES = 5
) (
  input  logic                       clk_25MHz,
  input  logic                       all_rst,
  input  logic                       start,
  bingo_board_writer_if.slave        req,
  output logic [124:0]               map,
  output logic                       busy,
  output logic                       board_ready,
  output logic [3:0]                 lines,
  output logic                       bingo
);

  typedef enum logic [2:0] {StIdle, StInit, StShuffle, StReady, StSearch} state_e;

  state_e      state_q;
  logic [15:0] lfsr_q;
  logic [4:0]  idx_q;
  logic [4:0]  num_q;
  logic [4:0]  cells_q [25];
  logic        br_q;
  logic        hit_q;
  logic        miss_q;
  logic [3:0]  lines_q;
  logic        bingo_q;

  logic [4:0]  rnd;
  logic [24:0] zero;
  logic        start_take;
  logic        keep_lines;
  int unsigned line_n;

  assign rnd        = lfsr_q[4:0];
  assign start_take = start && (state_q == StIdle || state_q == StReady);
  // A rebuild clears board_ready on this edge, so lines must already read 0 after it.
  assign keep_lines = br_q && !start_take;

  for (genvar c = 0; c < 25; c++) begin : g_cell
    assign zero[c]       = (cells_q[c] == 5'd0);
    assign map[5*c +: 5] = cells_q[c];
  end

  always_comb begin
    line_n = 0;
    for (int j = 0; j < 5; j++) begin
      if (zero[5*j +: 5] == 5'h1f) line_n = line_n + 1;
      if ({zero[j], zero[j+5], zero[j+10], zero[j+15], zero[j+20]} == 5'h1f) line_n = line_n + 1;
    end
    if ({zero[0], zero[6], zero[12], zero[18], zero[24]} == 5'h1f) line_n = line_n + 1;
    if ({zero[4], zero[8], zero[12], zero[16], zero[20]} == 5'h1f) line_n = line_n + 1;
  end

  always_ff @(posedge clk_25MHz) begin
    if (!all_rst) begin
      state_q <= StIdle;
      lfsr_q  <= LFSR_SEED;
      idx_q   <= '0;
      num_q   <= '0;
      br_q    <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      lines_q <= '0;
      bingo_q <= 1'b0;
      for (int c = 0; c < 25; c++) cells_q[c] <= '0;
    end else begin
      lfsr_q  <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      lines_q <= keep_lines ? 4'(line_n) : 4'd0;
      bingo_q <= keep_lines && (line_n >= WIN_LINES);
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StInit;
            idx_q   <= '0;
            br_q    <= 1'b0;
          end
        end
        StInit: begin
          cells_q[idx_q] <= idx_q + 5'd1;
          if (idx_q == 5'd24) begin
            state_q <= StShuffle;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        StShuffle: begin
          // Out-of-range draws are retried on the next LFSR value, keeping the shuffle unbiased.
          if (rnd <= idx_q) begin
            cells_q[idx_q] <= cells_q[rnd];
            cells_q[rnd]   <= cells_q[idx_q];
            if (idx_q == 5'd1) begin
              state_q <= StReady;
              br_q    <= 1'b1;
            end else begin
              idx_q <= idx_q - 5'd1;
            end
          end
        end
        StReady: begin
          if (start) begin
            state_q <= StInit;
            idx_q   <= '0;
            br_q    <= 1'b0;
          end else if (req.mark_valid) begin
            num_q   <= req.mark_num;
            idx_q   <= '0;
            state_q <= StSearch;
          end
        end
        StSearch: begin
          if (num_q == 5'd0 || num_q > 5'd25 || idx_q == 5'd25) begin
            miss_q  <= 1'b1;
            state_q <= StReady;
          end else if (cells_q[idx_q] == num_q) begin
            cells_q[idx_q] <= '0;
            hit_q          <= 1'b1;
            state_q        <= StReady;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req.mark_ready = (state_q == StReady);
  assign req.mark_hit   = hit_q;
  assign req.mark_miss  = miss_q;
  assign busy           = (state_q == StInit) || (state_q == StShuffle) || (state_q == StSearch);
  assign board_ready    = br_q;
  assign lines          = lines_q;
  assign bingo          = bingo_q;

endmodule

// File: tb/tb_bingo_board_writer.sv
// Randomised bench for bingo_board_writer against an event-level board model.
module tb_bingo_board_writer;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          WIN  = 5;

  logic         clk_25MHz = 1'b0;
  logic         all_rst;
  logic         start;
  logic [124:0] map;
  logic         busy;
  logic         board_ready;
  logic [3:0]   lines;
  logic         bingo;

  bingo_board_writer_if bus ();

  bingo_board_writer #(
    .LFSR_SEED(SEED),
    .WIN_LINES(WIN)
  ) dut (
    .clk_25MHz  (clk_25MHz),
    .all_rst    (all_rst),
    .start      (start),
    .req        (bus),
    .map        (map),
    .busy       (busy),
    .board_ready(board_ready),
    .lines      (lines),
    .bingo      (bingo)
  );

  always #5 clk_25MHz = ~clk_25MHz;

  typedef enum {PIdle, PBuild, PReady, PSearch} phase_e;

  phase_e      m_phase = PIdle;
  int          m_map [25];
  int          pend  [25];
  bit          m_br, m_hit, m_miss, m_bingo;
  int          m_lines;
  logic [15:0] m_lfsr = SEED;
  int          cyc = 0;
  int          done_at, hit_cell;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic timeout(input string name, input int waited);
    n_checks++;
    $display("FAIL %s: event absent after %0d cycles, required within bound", name, waited);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int count_lines(input int b [25]);
    int n, rz, cz, d1, d2;
    n = 0; d1 = 0; d2 = 0;
    for (int j = 0; j < 5; j++) begin
      rz = 0; cz = 0;
      for (int x = 0; x < 5; x++) begin
        if (b[x + 5*j] == 0) rz++;
        if (b[j + 5*x] == 0) cz++;
      end
      if (rz == 5) n++;
      if (cz == 5) n++;
      if (b[6*j] == 0) d1++;
      if (b[4*(j+1)] == 0) d2++;
    end
    if (d1 == 5) n++;
    if (d2 == 5) n++;
    return n;
  endfunction

  function automatic logic [124:0] pack(input int b [25]);
    logic [124:0] p;
    p = '0;
    for (int c = 0; c < 25; c++) p[5*c +: 5] = 5'(b[c]);
    return p;
  endfunction

  // Board built from a start seen while the LFSR held l0; returns the number of shuffle cycles.
  task automatic build(input logic [15:0] l0, output int cnt);
    logic [15:0] l;
    int i, r, tmp;
    l = l0;
    for (int s = 0; s < 26; s++) l = lfsr_step(l);
    for (int c = 0; c < 25; c++) pend[c] = c + 1;
    cnt = 0;
    i = 24;
    while (i >= 1) begin
      r = int'(l[4:0]);
      cnt++;
      if (r <= i) begin
        tmp = pend[i]; pend[i] = pend[r]; pend[r] = tmp;
        i--;
      end
      l = lfsr_step(l);
    end
  endtask

  task automatic model_step();
    int  prev [25];
    bit  br_prev;
    int  k, num;
    prev    = m_map;
    br_prev = m_br;
    cyc++;
    if (!all_rst) begin
      m_phase = PIdle;
      for (int c = 0; c < 25; c++) m_map[c] = 0;
      m_br = 0; m_hit = 0; m_miss = 0; m_lines = 0; m_bingo = 0;
      m_lfsr = SEED;
    end else begin
      m_hit = 0; m_miss = 0;
      case (m_phase)
        PIdle, PReady: begin
          if (start) begin
            build(m_lfsr, k);
            done_at = cyc + 25 + k;
            m_phase = PBuild;
            m_br    = 0;
          end else if (m_phase == PReady && bus.mark_valid) begin
            num      = int'(bus.mark_num);
            hit_cell = -1;
            m_phase  = PSearch;
            if (num < 1 || num > 25) done_at = cyc + 1;
            else begin
              for (int c = 0; c < 25; c++) if (m_map[c] == num && hit_cell < 0) hit_cell = c;
              done_at = (hit_cell < 0) ? cyc + 26 : cyc + 1 + hit_cell;
            end
          end
        end
        PBuild: begin
          if (cyc == done_at) begin
            m_map = pend; m_br = 1; m_phase = PReady;
          end
        end
        PSearch: begin
          if (cyc == done_at) begin
            if (hit_cell >= 0) begin
              m_map[hit_cell] = 0; m_hit = 1;
            end else m_miss = 1;
            m_phase = PReady;
          end
        end
        default: m_phase = PIdle;
      endcase
      m_lines = (br_prev && m_br) ? count_lines(prev) : 0;
      m_bingo = (m_lines >= WIN);
      m_lfsr  = lfsr_step(m_lfsr);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_25MHz);
      model_step();
      check("mark_ready", bus.mark_ready, m_phase == PReady);
      check("busy", busy, m_phase == PBuild || m_phase == PSearch);
      check("board_ready", board_ready, m_br);
      check("mark_hit", bus.mark_hit, m_hit);
      check("mark_miss", bus.mark_miss, m_miss);
      check("lines", lines, m_lines);
      check("bingo", bingo, m_bingo);
      if (m_phase != PBuild) check("map", map, pack(m_map));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_25MHz);
      #1;
    end
  endtask

  task automatic wait_ready();
    int w;
    for (w = 0; w < 3000 && !board_ready; w++) tick(1);
    if (!board_ready) timeout("wait_board_ready", w);
  endtask

  task automatic do_mark(input int num, input bit keep, output int t);
    bit rdy;
    bus.mark_valid = 1'b1;
    bus.mark_num   = 5'(num);
    rdy = bus.mark_ready;
    t   = -1;
    for (int w = 0; w < 100; w++) begin
      tick(1);
      if (rdy) begin
        t = cyc;
        break;
      end
      rdy = bus.mark_ready;
    end
    if (t < 0) timeout("mark_accept", 100);
    if (!keep) bus.mark_valid = 1'b0;
  endtask

  task automatic wait_pulse(input int t, output int lat, output bit hit);
    int w;
    for (w = 0; w < 60 && !(bus.mark_hit || bus.mark_miss); w++) tick(1);
    lat = cyc + 1 - t;
    hit = bus.mark_hit;
    if (!(bus.mark_hit || bus.mark_miss)) timeout("mark_result", w);
  endtask

  task automatic mark(input int num);
    int t, lat;
    bit hit;
    do_mark(num, 1'b0, t);
    wait_pulse(t, lat, hit);
  endtask

  task automatic check_perm(input string name);
    int seen [26];
    int v;
    bit ok;
    ok = 1;
    for (int i = 0; i < 26; i++) seen[i] = 0;
    for (int c = 0; c < 25; c++) begin
      v = int'(map[5*c +: 5]);
      if (v < 1 || v > 25) ok = 0;
      else seen[v]++;
    end
    for (int i = 1; i < 26; i++) if (seen[i] != 1) ok = 0;
    check(name, ok, 1'b1);
  endtask

  task automatic start_build();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    logic [124:0] board_a, board_b, saved;
    int           arr [25];
    int           cells [23];
    int           t, t2, lat, num;
    bit           hit;

    all_rst = 1'b0;
    start   = 1'b0;
    bus.mark_valid = 1'b0;
    bus.mark_num   = 5'd0;

    check("lfsr_pin0", lfsr_step(16'hACE1), 16'hE270);
    check("lfsr_pin1", lfsr_step(16'hE270), 16'h7138);
    for (int c = 0; c < 25; c++) arr[c] = (c < 5) ? 0 : c;
    check("lines_pin_row0", count_lines(arr), 1);
    for (int c = 0; c < 25; c++) arr[c] = 0;
    check("lines_pin_all", count_lines(arr), 12);

    tick(3);
    check("rst_map", map, 125'd0);
    check("rst_lines", lines, 4'd0);
    check("rst_ready", bus.mark_ready, 1'b0);

    // Board A: start on the first edge after reset releases.
    all_rst = 1'b1;
    start_build();
    check("busy_after_start", busy, 1'b1);
    wait_ready();
    board_a = map;
    check_perm("perm_a");

    // Board B: same seed, start one cycle later.
    all_rst = 1'b0;
    tick(2);
    all_rst = 1'b1;
    tick(1);
    start_build();
    wait_ready();
    board_b = map;
    check_perm("perm_b");
    check("perm_differs", board_a != board_b, 1'b1);

    // Hit at cell 12, then a repeat of the same number misses after a full scan.
    num = m_map[12];
    do_mark(num, 1'b0, t);
    wait_pulse(t, lat, hit);
    check("hit_latency", lat, 14);
    check("hit_flag", hit, 1'b1);
    check("cell12_cleared", map[60 +: 5], 5'd0);
    do_mark(num, 1'b1, t);
    bus.mark_num = 5'd0;
    wait_pulse(t, lat, hit);
    check("miss_latency", lat, 27);
    check("miss_flag", hit, 1'b0);
    saved = map;
    do_mark(0, 1'b0, t2);
    check("held_accept_gap", t2 - t, 27);
    wait_pulse(t2, lat, hit);
    check("zero_latency", lat, 2);
    do_mark(31, 1'b0, t);
    wait_pulse(t, lat, hit);
    check("range_latency", lat, 2);
    check("range_map_kept", map, saved);

    // Row 0, column 0, both diagonals, row 4 -> exactly five lines.
    cells = '{0, 1, 2, 3, 4, 5, 10, 15, 20, 6, 12, 18, 24, 8, 16, 21, 22, 23, 0, 0, 0, 0, 0};
    for (int i = 0; i < 18; i++) begin
      if (m_map[cells[i]] != 0) begin
        do_mark(m_map[cells[i]], 1'b0, t);
        wait_pulse(t, lat, hit);
      end
    end
    check("bingo_lags_hit", bingo, 1'b0);
    tick(1);
    check("five_lines", lines, 4'd5);
    check("bingo_set", bingo, 1'b1);

    for (int i = 0; i < 30; i++) mark($urandom_range(0, 31));

    // Start with a simultaneous mark request: start wins and lines drop at once.
    start = 1'b1;
    bus.mark_valid = 1'b1;
    bus.mark_num   = 5'(m_map[0] == 0 ? 1 : m_map[0]);
    tick(1);
    start = 1'b0;
    bus.mark_valid = 1'b0;
    check("rebuild_lines", lines, 4'd0);
    check("rebuild_bingo", bingo, 1'b0);
    check("rebuild_busy", busy, 1'b1);
    wait_ready();
    check_perm("perm_rebuild");

    // Reset in the middle of a shuffle.
    start_build();
    tick(30);
    all_rst = 1'b0;
    tick(1);
    check("rst_shuffle_map", map, 125'd0);
    check("rst_shuffle_busy", busy, 1'b0);
    check("rst_shuffle_br", board_ready, 1'b0);
    all_rst = 1'b1;
    tick(2);

    // Reset in the middle of a search.
    start_build();
    wait_ready();
    do_mark(m_map[24], 1'b0, t);
    tick(5);
    all_rst = 1'b0;
    tick(1);
    check("rst_search_map", map, 125'd0);
    check("rst_search_busy", busy, 1'b0);
    check("rst_search_ready", bus.mark_ready, 1'b0);
    check("rst_search_hit", bus.mark_hit, 1'b0);
    all_rst = 1'b1;

    for (int rep = 0; rep < 3; rep++) begin
      tick($urandom_range(0, 20));
      start_build();
      wait_ready();
      check_perm("perm_random");
      for (int i = 0; i < 12; i++) mark($urandom_range(0, 31));
    end
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bingo_board_writer.md
Name: bingo_board_writer

Overview:
- Owns and writes the 5x5 bingo board map that the display path reads.
- On start, fills the board with a pseudo-random permutation of 1..25:
  - sequential init pass;
  - Fisher-Yates shuffle driven by a free-running LFSR.
- Afterwards it accepts "number called" requests over a valid/ready handshake, searches the board and clears the matching cell to 0.
- Maintains a registered count of completed lines and a bingo flag for the game controller.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset; must be nonzero.
- WIN_LINES, 5, completed-line count at which bingo asserts.

Ports:
- clk_25MHz  input  1  system clock, all logic on rising edge.
- all_rst  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to (re)build the board.
- mark_valid  input  1  mark request valid.
- mark_num  input  5  number to mark; legal range 1..25.
- mark_ready  output  1  high only in READY; handshake completes when mark_valid && mark_ready.
- map  output  125  board; cell i = x+5*y at map[5*i+4:5*i]; 0 = marked/empty, 1..25 = unmarked number.
- busy  output  1  high in INIT, SHUFFLE, SEARCH.
- board_ready  output  1  high once a shuffle has completed; cleared by reset or an accepted start.
- mark_hit  output  1  one-cycle pulse, requested number found and cleared.
- mark_miss  output  1  one-cycle pulse, number absent, already marked, or out of range.
- lines  output  4  completed lines, 0..12 (5 rows, 5 cols, 2 diagonals).
- bingo  output  1  lines >= WIN_LINES.

Behaviour:
- Reset (all_rst==0 at a clock edge):
  - map=0, state=IDLE, lfsr=LFSR_SEED;
  - all outputs 0 (mark_ready, busy, board_ready, mark_hit, mark_miss, lines, bingo).
- LFSR:
  - 16-bit Galois, mask 16'hB400, shifts right every cycle in every state except reset;
  - entropy therefore comes from the start time.
- States: IDLE, INIT, SHUFFLE, READY, SEARCH.
- IDLE:
  - start -> INIT, idx=0, board_ready=0.
- INIT:
  - writes cell idx = idx+1, one cell per cycle, 25 cycles;
  - after cell 24 -> SHUFFLE with i=24.
- SHUFFLE:
  - r = lfsr[4:0] each cycle;
  - if r <= i: swap cells i and r in that cycle (r==i is a legal no-op), then i = i-1;
  - else retry next cycle with no swap;
  - after the i==1 swap -> READY, board_ready=1.
  - Result is always a permutation of 1..25; every value appears exactly once.
- READY:
  - mark_ready=1.
  - Accepted mark (cycle T) latches mark_num -> SEARCH, k=0.
  - start in READY -> INIT; a same-cycle mark_valid is not accepted.
- SEARCH (k=0..24, one cell per cycle):
  - Latched num 0 or >25: mark_miss visible at T+2, back to READY; no scan.
  - On a match at cell k (cycle T+1+k): at that edge the cell is written 0, mark_hit asserts (visible T+2+k), state returns to READY.
  - No match through k=24: mark_miss visible at T+27, map unchanged.
  - Marking an already-cleared number is a miss.
- start is ignored in INIT, SHUFFLE and SEARCH.
- mark_valid outside READY is not accepted; requesters hold it until mark_ready.
- lines and bingo:
  - registered and recomputed every cycle from the zero-mask of map, so they lag map by one cycle;
  - forced to 0 while board_ready==0, including during a rebuild.
- Reset mid-operation (any state) aborts immediately to the reset values; no partial map survives.

Test Plan:
- Reset -> map==0, lines==0, bingo==0, mark_ready==0; start at cycle 10 -> busy==1; board_ready rises after 25 INIT cycles plus the shuffle cycles; map holds each of 1..25 exactly once.
- LFSR_SEED=16'hACE1, start on the first cycle after reset -> map matches the golden permutation from the bench model; repeating with start one cycle later gives a different permutation.
- Board ready, value 7 at cell 12 -> mark_num=7 accepted at T -> mark_hit visible at T+14 and cell 12 ==0; mark 7 again -> mark_miss visible at T'+27.
- mark_num=0 and mark_num=31 -> mark_miss at T+2, map unchanged; mark_valid held during SEARCH is not accepted until mark_ready returns.
- Mark all numbers in row 0, column 0, both diagonals and row 4 -> lines counts up to 5 and bingo==1 one cycle after the fifth line's mark_hit; start -> lines==0, bingo==0, rebuild proceeds.
- Assert all_rst low mid-SHUFFLE and mid-SEARCH -> next cycle all outputs are at their reset values and the state is IDLE.
